// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: shared types and constants for the two-port SRAM arbiter.
//   state_e   - arbiter FSM states
//   PORT_A/B  - port-select encoding used by the grant logic and the FSM
//   WAIT_W    - width of the ACCESS down-counter (WAIT_CYCLES up to 15)
package sram_arb_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StAccess,
        StDone
    } state_e;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    localparam int unsigned WAIT_W = 4;

endpackage

// File: rtl/sram_arb_grant.sv
// sram_arb_grant: combinational winner selection between the two requesters.
// Optional feature macro: SRAM_ARB_ROUND_ROBIN_EN
//   defined   - round-robin: on a tie the port not granted last wins
//   undefined - fixed priority: port A always wins a tie
// Ports:
//   a_req, b_req  in   request levels
//   last_grant    in   port granted by the previous arbitration
//   grant_valid   out  at least one request present
//   grant_port    out  winning port (PORT_A / PORT_B)
module sram_arb_grant
    import sram_arb_pkg::*;
(
    input  logic a_req,
    input  logic b_req,
    input  logic last_grant,
    output logic grant_valid,
    output logic grant_port
);

    always_comb begin
        grant_valid = a_req | b_req;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
        if (a_req && b_req) begin
            grant_port = (last_grant == PORT_A) ? PORT_B : PORT_A;
        end else begin
            grant_port = a_req ? PORT_A : PORT_B;
        end
`else
        grant_port = a_req ? PORT_A : PORT_B;
`endif
    end

`ifndef SRAM_ARB_ROUND_ROBIN_EN
    // History is irrelevant under fixed priority.
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
`endif

endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one asynchronous 16-bit SRAM between two byte-wide
// requesters (A = video / high priority, B = CPU / loader) and sequences the
// SRAM pins: IDLE -> SETUP -> ACCESS (WAIT_CYCLES) -> DONE -> IDLE.
// Grant policy is selected by SRAM_ARB_ROUND_ROBIN_EN (see sram_arb_grant).
// Ports:
//   sysclk, reset              clock, synchronous active-high reset
//   a_*/b_*                    requester ports: req level, byte addr, we, wdata,
//                              rdata (held until next read of that port), ack pulse
//   ram_addr                   SRAM word address (byte addr >> 1)
//   ram_data_o / ram_data_i    pad write / read data
//   ram_data_oe                drive pads when 1
//   ram_ce_n ... ram_ub_n      active-low SRAM controls
//   busy                       FSM not in IDLE
// All outputs are registered.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned ADDR_W      = 22
) (
    input  logic              sysclk,
    input  logic              reset,
    input  logic              a_req,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic              a_we,
    input  logic [7:0]        a_wdata,
    output logic [7:0]        a_rdata,
    output logic              a_ack,
    input  logic              b_req,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic              b_we,
    input  logic [7:0]        b_wdata,
    output logic [7:0]        b_rdata,
    output logic              b_ack,
    output logic [ADDR_W-2:0] ram_addr,
    output logic [15:0]       ram_data_o,
    input  logic [15:0]       ram_data_i,
    output logic              ram_data_oe,
    output logic              ram_ce_n,
    output logic              ram_oe_n,
    output logic              ram_we_n,
    output logic              ram_lb_n,
    output logic              ram_ub_n,
    output logic              busy
);

    localparam logic [WAIT_W-1:0] WaitLoad = WAIT_W'(WAIT_CYCLES - 1);

    state_e            state_q;
    logic [WAIT_W-1:0] cnt_q;
    logic              port_q;
    logic              we_q;
    logic              ub_q;
    logic              last_grant_q;

    logic              grant_valid;
    logic              grant_port;
    logic [ADDR_W-1:0] sel_addr;
    logic              sel_we;
    logic [7:0]        sel_wdata;
    logic [7:0]        rd_byte;

    sram_arb_grant u_grant (
        .a_req       (a_req),
        .b_req       (b_req),
        .last_grant  (last_grant_q),
        .grant_valid (grant_valid),
        .grant_port  (grant_port)
    );

    always_comb begin
        sel_addr  = a_addr;
        sel_we    = a_we;
        sel_wdata = a_wdata;
        if (grant_port == PORT_B) begin
            sel_addr  = b_addr;
            sel_we    = b_we;
            sel_wdata = b_wdata;
        end
    end

    assign rd_byte = ub_q ? ram_data_i[15:8] : ram_data_i[7:0];

    // Pin registers are loaded with the values of the state being entered, so
    // the pins always reflect the current state without combinational paths.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            port_q       <= PORT_A;
            we_q         <= 1'b0;
            ub_q         <= 1'b0;
            last_grant_q <= PORT_B;
            a_rdata      <= '0;
            b_rdata      <= '0;
            a_ack        <= 1'b0;
            b_ack        <= 1'b0;
            ram_addr     <= '0;
            ram_data_o   <= '0;
            ram_data_oe  <= 1'b0;
            ram_ce_n     <= 1'b1;
            ram_oe_n     <= 1'b1;
            ram_we_n     <= 1'b1;
            ram_lb_n     <= 1'b1;
            ram_ub_n     <= 1'b1;
            busy         <= 1'b0;
        end else begin
            a_ack <= 1'b0;
            b_ack <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (grant_valid) begin
                        state_q      <= StSetup;
                        busy         <= 1'b1;
                        port_q       <= grant_port;
                        last_grant_q <= grant_port;
                        we_q         <= sel_we;
                        ub_q         <= sel_addr[0];
                        ram_addr     <= sel_addr[ADDR_W-1:1];
                        ram_data_o   <= {sel_wdata, sel_wdata};
                        ram_ce_n     <= 1'b0;
                        ram_lb_n     <= sel_addr[0];
                        ram_ub_n     <= ~sel_addr[0];
                        // Reads enable the SRAM output, writes drive the bus;
                        // never both.
                        ram_oe_n     <= sel_we;
                        ram_data_oe  <= sel_we;
                    end
                end
                StSetup: begin
                    state_q  <= StAccess;
                    cnt_q    <= WaitLoad;
                    ram_we_n <= ~we_q;
                end
                StAccess: begin
                    if (cnt_q == '0) begin
                        state_q  <= StDone;
                        ram_we_n <= 1'b1;
                        ram_oe_n <= 1'b1;
                        if (port_q == PORT_B) begin
                            b_ack <= 1'b1;
                            if (!we_q) b_rdata <= rd_byte;
                        end else begin
                            a_ack <= 1'b1;
                            if (!we_q) a_rdata <= rd_byte;
                        end
                    end else begin
                        cnt_q <= cnt_q - WAIT_W'(1);
                    end
                end
                StDone: begin
                    // Address and data were held through DONE for hold time.
                    state_q     <= StIdle;
                    busy        <= 1'b0;
                    ram_ce_n    <= 1'b1;
                    ram_lb_n    <= 1'b1;
                    ram_ub_n    <= 1'b1;
                    ram_data_oe <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares the board's single asynchronous 16-bit SRAM between two byte-wide requesters. Port A is video/high priority; port B is CPU/loader.
- Sequences every access on the SRAM pins: chip enable, output enable, write enable, byte lanes and the data-bus tristate control.
- Sits between the core's memory clients and the top-level SRAM pads.
- Replaces the tie-offs currently used there: permanent CE/OE low, upper byte lane disabled.

Parameters:
- WAIT_CYCLES, 2: sysclk cycles spent in ACCESS (OE or WE active). Legal range 1..15.
- ADDR_W, 22: requester byte-address width. SRAM word address = addr[ADDR_W-1:1].

Ports:
- sysclk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- a_req  in  1  port A request level; addr/we/wdata must stay stable until a_ack.
- a_addr  in  ADDR_W  port A byte address.
- a_we  in  1  1=write, 0=read.
- a_wdata  in  8  port A write byte.
- a_rdata  out  8  port A read byte; valid with a_ack, held until the next A read completes.
- a_ack  out  1  one-cycle completion pulse.
- b_req, b_addr, b_we, b_wdata, b_rdata, b_ack: same widths and rules as port A, for port B.
- ram_addr  out  ADDR_W-1  SRAM word address.
- ram_data_o  out  16  write data, {wdata,wdata}.
- ram_data_i  in  16  read data from the pads.
- ram_data_oe  out  1  1 = drive pads; the top level tristates the pads when this is 0.
- ram_ce_n, ram_oe_n, ram_we_n, ram_lb_n, ram_ub_n  out  1 each  active-low SRAM controls.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values: all _n outputs 1; ram_data_oe 0; ram_addr 0; ram_data_o 0; acks 0; rdata 0; busy 0; FSM in IDLE.
- All outputs are registered.
- FSM states: IDLE -> SETUP -> ACCESS (WAIT_CYCLES cycles) -> DONE -> IDLE.
- IDLE:
  - Samples a_req and b_req and grants one requester.
  - Latches the granted port's addr, we and wdata into internal registers.
  - No request: remains in IDLE.
- SETUP (1 cycle):
  - ram_addr = addr[ADDR_W-1:1].
  - Byte lane: addr[0]=0 -> lb_n=0, ub_n=1; addr[0]=1 -> lb_n=1, ub_n=0.
  - ce_n=0.
  - Read: oe_n=0. Write: oe_n=1 and data_oe=1.
- ACCESS:
  - A down-counter loaded with WAIT_CYCLES-1 counts to 0.
  - Write: we_n=0 throughout.
  - Read: on the last ACCESS cycle, the selected lane of ram_data_i (lb -> [7:0], ub -> [15:8]) is captured into the granted port's rdata.
- DONE (1 cycle):
  - we_n=1 and oe_n=1.
  - Address, ce_n, lanes and data_oe are held for one cycle (hold time).
  - The granted port's ack=1.
- After DONE the FSM returns to IDLE. There ce_n, lb_n, ub_n return to 1 and data_oe to 0.
- Latency: req sampled at edge 0 -> ack high during cycle WAIT_CYCLES+2.
- Throughput: one access per WAIT_CYCLES+3 cycles.
- Requesters drop or renew req in the cycle after ack. A req still high in IDLE after ack starts a new access.
- Simultaneous requests: resolved by the grant policy below. The loser keeps req high and is served next.
- A req asserted while busy is not sampled until IDLE.
- Deasserting req before ack is illegal. The latched transaction completes regardless.
- Reset mid-operation: the FSM goes to IDLE on the next edge with all pins inactive. The transaction is dropped, no ack is issued and the rdata registers are cleared.
- ram_data_oe and oe_n=0 are never both active in the same cycle.

Optional Feature:
- Macro SRAM_ARB_ROUND_ROBIN_EN.
- Defined: round-robin grant. A 1-bit last_grant register (reset = B, so A wins the first tie) favours the port not granted last when both request.
- Undefined: fixed priority, A always wins ties. B can starve under continuous A requests.

Decomposition:
- Package sram_arb_pkg holds:
  - the state enum (IDLE, SETUP, ACCESS, DONE);
  - port-select constants PORT_A=0 and PORT_B=1;
  - the WAIT counter width (4 bits).
- One sub-module, sram_arb_grant:
  - combinational winner selection from a_req, b_req and last_grant;
  - contains the SRAM_ARB_ROUND_ROBIN_EN ifdef.
- The FSM, latches and pin registers stay in sram_arbiter.

Test Plan:
- Port A write addr 0x00001, data 0xA5, WAIT_CYCLES=2 -> ram_addr=0; ub_n=0, lb_n=1; we_n low for exactly 2 cycles; data_oe high SETUP..DONE; a_ack pulses 4 cycles after the sampling edge.
- Port B read addr 0x00000 with ram_data_i=0x3C7E -> b_rdata=0x7E, b_ack one cycle; oe_n low SETUP..ACCESS; data_oe stays 0.
- a_req and b_req held high for 4 accesses:
  - with the macro: grants A, B, A, B;
  - without the macro: grants A, A, A, A and b_ack never pulses.
- Reset asserted during ACCESS of a write -> next cycle all _n=1, data_oe=0, no ack; a subsequent read request works normally.
- Back-to-back reads on port A from addresses 0x10, 0x11 with ram_data_i=0x55AA -> a_rdata 0xAA then 0x55; acks spaced WAIT_CYCLES+3 cycles apart.
